mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single-port program/data memory.
- Port 0 is the bird CPU data path; port 1 is a secondary master (DMA/peripheral engine).
- Sequences every memory access through a fixed 4-cycle FSM with round-robin fairness.
- Returns read data and a one-cycle acknowledge to whichever requester was granted.

Parameters:
- AW, 16, address width of requesters and memory
- DW, 16, data width of requesters and memory

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- req0  in  1  port 0 request; held high until ack0
- we0  in  1  port 0 write (1) / read (0); stable while req0
- addr0  in  AW  port 0 address; stable while req0
- wdata0  in  DW  port 0 write data; stable while req0
- rdata0  out  DW  port 0 read data; valid when ack0=1
- ack0  out  1  port 0 completion pulse
- req1, we1, addr1, wdata1, rdata1, ack1: same as port 0, for port 1
- mem_addr  out  AW  memory address (registered)
- mem_wdata  out  DW  memory write data (registered)
- mem_we  out  1  memory write enable (registered)
- mem_rdata  in  DW  memory read data, synchronous: valid the cycle after mem_addr is presented
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset, sampled at clk edge, overrides everything:
  - state=IDLE, last=1 (so port 0 wins the first tie).
  - ack0=ack1=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, busy=0.
- States: IDLE, ACCESS, CAPTURE, ACK.
- IDLE:
  - Only req0 high -> grant 0. Only req1 high -> grant 1.
  - Both high -> grant the port != last.
  - On grant: store gnt; set last=gnt; load mem_addr/mem_wdata/mem_we from the granted port; go to ACCESS.
  - No req -> stay in IDLE. weN without reqN is ignored.
- ACCESS: mem_addr/mem_we held; memory samples at end of cycle. Clear mem_we at exit, so a write pulses mem_we for exactly 1 cycle. Go to CAPTURE.
- CAPTURE: mem_rdata valid. If the access is a read, register mem_rdata into rdata[gnt]; writes leave rdata unchanged. Set ack[gnt]=1 at exit. Go to ACK.
- ACK: ack[gnt]=1 for exactly this cycle; the other ack stays 0. Clear ack at exit. Go to IDLE.
- Latency: request sampled in IDLE at cycle n -> mem_addr valid cycle n+1 -> ack high cycle n+3 -> IDLE cycle n+4.
  - Peak throughput is one access per 4 cycles.
  - A requester that keeps req high after ack is re-arbitrated in IDLE like a new request.
- rdataN holds its last read value until the next read completes on that port.
- mem_addr, mem_wdata and gnt hold their values after a transaction completes until the next grant.
- Fairness:
  - With both ports continuously requesting, grants alternate 0,1,0,1.
  - No port waits longer than one foreign transaction (≤ 4 cycles) after its request is seen in IDLE.
- Protocol violations:
  - A requester dropping reqN or changing fields mid-transaction does not abort it; the latched values are used and ack still pulses.
  - Only the latched request is served.
- Reset mid-transaction (any non-IDLE state):
  - Aborts with no ack. mem_we=0 from the next cycle.
  - The next arbitration favours port 0.
- Addresses are passed through unmodified; 16'hFFFF is legal, with no wrap or offset arithmetic.
- Exactly one of ack0/ack1 may be high in any cycle; never both.

Test Plan:
- Port 0 read: mem[16'h0010]=16'hBEEF, pulse req0 with we0=0 -> mem_addr=16'h0010 in cycle n+1, ack0=1 only in n+3, rdata0=16'hBEEF, mem_we never high.
- Port 1 write: addr1=16'h00A0, wdata1=16'h1234, we1=1 -> mem_we=1 exactly in n+1, then a port 0 read of 16'h00A0 returns 16'h1234; rdata1 unchanged.
- Simultaneous requests right after reset: req0=req1=1 both held -> ack order 0,1,0,1 across 4 transactions, ack pulses 4 cycles apart, never overlapping.
- Starvation check: req0 held continuously, req1 raised while port 0 is in ACCESS -> port 1 granted on the next IDLE; ack1 arrives within 8 cycles of req1.
- Reset mid-operation: assert rst in ACCESS of a write -> no ack, mem_we=0 next cycle, busy=0, state IDLE; a following tied request goes to port 0.
- Boundary address: read addr0=16'hFFFF with mem[16'hFFFF]=16'h0001 -> mem_addr=16'hFFFF, rdata0=16'h0001, busy high for exactly 3 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for the shared single-port program/data memory.
// Latency: grant in IDLE at n, mem_addr at n+1, ack at n+3; requesters hold req until ack (no queueing).
module mem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic [DW-1:0] rdata0,
    output logic          ack0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic [DW-1:0] rdata1,
    output logic          ack1,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    state_t state_q, state_d;
    acc_t   acc_q, acc_sel;
    logic   gnt_q, gnt_d;
    logic   last_q;
    logic   grant;

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        gnt_d   = gnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant   = 1'b1;
                    // On a tie the port that did not win last time goes first.
                    gnt_d   = (req0 && req1) ? ~last_q : req1;
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        acc_sel = gnt_d ? {we1, addr1, wdata1} : {we0, addr0, wdata0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            acc_q   <= '0;
            mem_we  <= 1'b0;
            ack0    <= 1'b0;
            ack1    <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            state_q <= state_d;
            ack0    <= (state_q == CAPTURE) && !gnt_q;
            ack1    <= (state_q == CAPTURE) && gnt_q;
            if (grant) begin
                gnt_q  <= gnt_d;
                last_q <= gnt_d;
                acc_q  <= acc_sel;
                mem_we <= acc_sel.we;
            end else if (state_q == ACCESS) begin
                mem_we <= 1'b0;
            end
            // Memory read data is valid in CAPTURE; writes leave rdata alone.
            if ((state_q == CAPTURE) && !acc_q.we) begin
                if (gnt_q) rdata1 <= mem_rdata;
                else       rdata0 <= mem_rdata;
            end
        end
    end

    assign mem_addr  = acc_q.addr;
    assign mem_wdata = acc_q.wdata;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_mem_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          ack0, ack1;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Synchronous single-port memory driven by the DUT.
    logic [DW-1:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    // Reference model: memory contents and a timeline of expected events.
    logic [DW-1:0] model_mem [0:65535];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int free_at, last, busy_lo, busy_hi, we_cyc, rst_chk;
    int ack_cyc [2];
    logic [DW-1:0] exp_rd [2];
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    int mode [2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        free_at   = cyc + 1;
        last      = 1;
        busy_lo   = -10;
        busy_hi   = -10;
        we_cyc    = -10;
        ack_cyc[0] = -10;
        ack_cyc[1] = -10;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        exp_addr  = '0;
        exp_wdata = '0;
        rst_chk   = cyc + 1;
    endtask

    // Evaluates the arbitration decision for the cycle now ending.
    task automatic model_arb();
        int w;
        logic pwe;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        if (rst) begin
            model_reset();
            return;
        end
        if (cyc >= free_at && (req0 || req1)) begin
            if (req0 && req1) w = 1 - last;
            else              w = req1 ? 1 : 0;
            pwe = (w == 1) ? we1 : we0;
            pa  = (w == 1) ? addr1 : addr0;
            pd  = (w == 1) ? wdata1 : wdata0;
            busy_lo    = cyc + 1;
            busy_hi    = cyc + 3;
            ack_cyc[w] = cyc + 3;
            we_cyc     = pwe ? cyc + 1 : -10;
            exp_addr   = pa;
            exp_wdata  = pd;
            if (pwe) model_mem[pa] = pd;
            else     exp_rd[w] = model_mem[pa];
            free_at = cyc + 4;
            last    = w;
        end
    endtask

    task automatic check_cycle();
        chk_eq("ack0", 32'(ack0), 32'(ack_cyc[0] == cyc));
        chk_eq("ack1", 32'(ack1), 32'(ack_cyc[1] == cyc));
        chk_eq("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
        chk_eq("mem_we", 32'(mem_we), 32'(cyc == we_cyc));
        chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
        chk_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
        if (cyc == ack_cyc[0] || cyc == ack_cyc[1] || cyc == rst_chk) begin
            chk_eq("rdata0", 32'(rdata0), 32'(exp_rd[0]));
            chk_eq("rdata1", 32'(rdata1), 32'(exp_rd[1]));
        end
    endtask

    task automatic next_cycle();
        model_arb();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic issue(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    task automatic drop(input int p);
        if (p == 0) begin req0 = 1'b0; we0 = 1'($urandom_range(0, 1)); end
        else        begin req1 = 1'b0; we1 = 1'($urandom_range(0, 1)); end
    endtask

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = $urandom_range(0, 8);
        if (r == 8) return 16'hFFFF;
        return AW'(r);
    endfunction

    task automatic issue_rand(input int p);
        issue(p, 1'($urandom_range(0, 1)), pick_addr(), DW'($urandom));
    endtask

    // mode 0: drop on ack; 1: random new requests; 2: re-request immediately after ack.
    task automatic drive();
        for (int p = 0; p < 2; p++) begin
            logic a, r;
            a = (p == 1) ? ack1 : ack0;
            r = (p == 1) ? req1 : req0;
            if (a) begin
                if (mode[p] == 2) issue_rand(p);
                else              drop(p);
            end else if (mode[p] == 1 && !r && $urandom_range(0, 2) == 0) begin
                issue_rand(p);
            end
        end
    endtask

    task automatic wait_ack(input int p, input int maxc, output int got_cyc);
        got_cyc = -1;
        for (int i = 0; i < maxc; i++) begin
            next_cycle();
            if ((p == 1) ? ack1 : ack0) begin
                got_cyc = cyc;
                drop(p);
                break;
            end
        end
        chk_eq("ack_seen", 32'(got_cyc >= 0), 32'd1);
    endtask

    task automatic drain(input int n);
        mode[0] = 0;
        mode[1] = 0;
        rst = 1'b0;
        for (int i = 0; i < n; i++) begin
            next_cycle();
            drive();
        end
    endtask

    initial begin
        int n, g, k, prev, raise, nb;
        logic [1:0] first;
        rst = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mode[0] = 0;
        mode[1] = 0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] <= DW'(i * 7) ^ 16'h5A5A;
            model_mem[i] = DW'(i * 7) ^ 16'h5A5A;
        end
        mem[16'h0010] <= 16'hBEEF;
        model_mem[16'h0010] = 16'hBEEF;
        mem[16'hFFFF] <= 16'h0001;
        model_mem[16'hFFFF] = 16'h0001;

        next_cycle();
        next_cycle();
        rst = 1'b0;

        // Port 0 read issued as a single-cycle pulse.
        issue(0, 1'b0, 16'h0010, 16'h7777);
        n = cyc;
        next_cycle();
        drop(0);
        chk_eq("t1_addr", 32'(mem_addr), 32'h0010);
        wait_ack(0, 6, g);
        chk_eq("t1_lat", 32'(g - n), 32'd3);
        chk_eq("t1_rdata", 32'(rdata0), 32'hBEEF);

        // Port 1 write, then port 0 reads it back.
        issue(1, 1'b1, 16'h00A0, 16'h1234);
        wait_ack(1, 8, g);
        issue(0, 1'b0, 16'h00A0, 16'h0000);
        wait_ack(0, 8, g);
        chk_eq("t2_rdata", 32'(rdata0), 32'h1234);

        // Boundary address read.
        drain(2);
        issue(0, 1'b0, 16'hFFFF, 16'h0000);
        nb = 0;
        for (int i = 0; i < 7; i++) begin
            next_cycle();
            if (i == 0) chk_eq("t6_addr", 32'(mem_addr), 32'hFFFF);
            if (busy) nb++;
            if (ack0) begin
                chk_eq("t6_rdata", 32'(rdata0), 32'h0001);
                drop(0);
            end
        end
        chk_eq("t6_busy_len", 32'(nb), 32'd3);

        // Both ports continuously requesting right after reset.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mode[0] = 2;
        mode[1] = 2;
        issue_rand(0);
        issue_rand(1);
        k = 0;
        prev = -1;
        for (int i = 0; i < 24 && k < 4; i++) begin
            next_cycle();
            if (ack0 || ack1) begin
                chk_eq("t3_order", 32'(ack1), 32'(k % 2));
                if (k > 0) chk_eq("t3_gap", 32'(cyc - prev), 32'd4);
                prev = cyc;
                k++;
            end
            drive();
        end
        chk_eq("t3_count", 32'(k), 32'd4);
        drain(12);

        // Port 1 raised while port 0 holds the memory.
        mode[0] = 2;
        issue_rand(0);
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            drive();
            if (busy) break;
        end
        issue_rand(1);
        raise = cyc;
        g = -1;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            if (ack1 && g < 0) g = cyc;
            drive();
        end
        chk_eq("t4_lat", 32'(g >= 0 && (g - raise) <= 8), 32'd1);
        drain(12);

        // Reset during the ACCESS cycle of a write.
        issue(1, 1'b1, 16'h0003, 16'hCAFE);
        next_cycle();
        chk_eq("t5_we", 32'(mem_we), 32'd1);
        rst = 1'b1;
        drop(1);
        next_cycle();
        chk_eq("t5_busy", 32'(busy), 32'd0);
        chk_eq("t5_we_clr", 32'(mem_we), 32'd0);
        rst = 1'b0;
        issue(0, 1'b0, 16'h0003, 16'h0000);
        issue(1, 1'b0, 16'h0004, 16'h0000);
        first = 2'b00;
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            first = {ack1, ack0};
            drive();
            if (first != 2'b00) break;
        end
        chk_eq("t5_first", 32'(first), 32'h1);
        drain(12);

        // Random traffic with occasional resets.
        mode[0] = 1;
        mode[1] = 1;
        for (int i = 0; i < 400; i++) begin
            next_cycle();
            drive();
            rst = ($urandom_range(0, 99) == 0);
        end
        drain(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
